// File: rtl/sort_sequencer_if.sv
// Stream bundle for the sort sequencer: load port, drain port and busy flag.
// The slave modport is the sequencer's view; master is the producer/consumer side.
interface sort_sequencer_if #(
    parameter int N = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic         out_last;
    logic         busy;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, busy
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, busy
    );
endinterface

// File: rtl/sort_sequencer.sv
// Frame sorter: loads up to DEPTH words, bubble-sorts them in place one compare per
// cycle (stable, ascending, optional signed order), then streams them out.
module sort_sequencer #(
    parameter int N      = 4,
    parameter int DEPTH  = 8,
    parameter int SIGNED = 0
) (
    input logic              clk,
    input logic              rst,
    sort_sequencer_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SORT, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   rd_q, rd_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic            swapped_q, swapped_d;
    logic [N-1:0]    mem [DEPTH];

    logic            in_fire;
    logic            load_en;
    logic            swap_en;
    logic            rd_last;
    logic [AW-1:0]   hi_idx;

    // Two's-complement order only differs from unsigned when the sign bits differ.
    function automatic logic greater(input logic [N-1:0] a, input logic [N-1:0] b);
        if (SIGNED != 0 && a[N-1] != b[N-1])
            return b[N-1];
        return a > b;
    endfunction

    assign bus.in_ready  = (state_q == IDLE) || (state_q == LOAD);
    assign bus.out_valid = (state_q == DRAIN);
    assign bus.busy      = (state_q == SORT) || (state_q == DRAIN);
    assign rd_last       = (CW'(rd_q) == cnt_q - CW'(1));
    assign bus.out_last  = bus.out_valid && rd_last;
    assign bus.out_data  = bus.out_valid ? mem[rd_q] : '0;
    assign in_fire       = bus.in_valid && bus.in_ready;
    assign hi_idx        = idx_q + AW'(1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_d      = rd_q;
        idx_d     = idx_q;
        swapped_d = swapped_q;
        load_en   = 1'b0;
        swap_en   = 1'b0;
        case (state_q)
            IDLE, LOAD: begin
                if (in_fire) begin
                    load_en = 1'b1;
                    cnt_d   = cnt_q + CW'(1);
                    if (bus.in_last || cnt_q == CW'(DEPTH - 1)) begin
                        state_d   = SORT;
                        idx_d     = '0;
                        swapped_d = 1'b0;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            SORT: begin
                if (cnt_q <= CW'(1)) begin
                    state_d = DRAIN;
                    rd_d    = '0;
                end else begin
                    swap_en = greater(mem[idx_q], mem[hi_idx]);
                    // A pass with no swaps at its last compare means the frame is ordered.
                    if (CW'(idx_q) == cnt_q - CW'(2)) begin
                        idx_d     = '0;
                        swapped_d = 1'b0;
                        if (!(swapped_q || swap_en)) begin
                            state_d = DRAIN;
                            rd_d    = '0;
                        end
                    end else begin
                        idx_d     = hi_idx;
                        swapped_d = swapped_q || swap_en;
                    end
                end
            end
            DRAIN: begin
                if (bus.out_ready) begin
                    if (rd_last) begin
                        state_d   = IDLE;
                        cnt_d     = '0;
                        rd_d      = '0;
                        idx_d     = '0;
                        swapped_d = 1'b0;
                    end else begin
                        rd_d = rd_q + AW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rd_q      <= '0;
            idx_q     <= '0;
            swapped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_q      <= rd_d;
            idx_q     <= idx_d;
            swapped_q <= swapped_d;
        end
    end

    // Storage is not reset; only the counters decide which entries are meaningful.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[cnt_q[AW-1:0]] <= bus.in_data;
        end else if (swap_en) begin
            mem[idx_q]  <= mem[hi_idx];
            mem[hi_idx] <= mem[idx_q];
        end
    end
endmodule

// File: tb/tb_sort_sequencer.sv
// Directed bench for sort_sequencer: an unsigned and a signed instance, a reference
// stable sort feeding a scoreboard queue, and drain-side comparison against it.
module tb_sort_sequencer;
    localparam int N     = 4;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         sel;
    logic         inValid;
    logic [N-1:0] inData;
    logic         inLast;
    logic         outReady;

    sort_sequencer_if #(.N(N)) busU ();
    sort_sequencer_if #(.N(N)) busS ();

    sort_sequencer #(.N(N), .DEPTH(DEPTH), .SIGNED(0)) dutU (.clk(clk), .rst(rst), .bus(busU.slave));
    sort_sequencer #(.N(N), .DEPTH(DEPTH), .SIGNED(1)) dutS (.clk(clk), .rst(rst), .bus(busS.slave));

    assign busU.in_valid  = inValid && !sel;
    assign busU.in_data   = inData;
    assign busU.in_last   = inLast;
    assign busU.out_ready = outReady && !sel;
    assign busS.in_valid  = inValid && sel;
    assign busS.in_data   = inData;
    assign busS.in_last   = inLast;
    assign busS.out_ready = outReady && sel;

    logic         obsInReady, obsOutValid, obsOutLast, obsBusy;
    logic [N-1:0] obsOutData;
    assign obsInReady  = sel ? busS.in_ready  : busU.in_ready;
    assign obsOutValid = sel ? busS.out_valid : busU.out_valid;
    assign obsOutLast  = sel ? busS.out_last  : busU.out_last;
    assign obsOutData  = sel ? busS.out_data  : busU.out_data;
    assign obsBusy     = sel ? busS.busy      : busU.busy;

    int compared   = 0;
    int mismatched = 0;

    logic [N-1:0] frame [$];
    logic [N:0]   expQ  [$];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic bit greaterRef(input logic [N-1:0] a, input logic [N-1:0] b);
        if (sel)
            return $signed(a) > $signed(b);
        return a > b;
    endfunction

    // Drives the current frame word by word and queues its stable-sorted image.
    task automatic applyStimulus(input bit useLast);
        logic [N-1:0] s [$];
        logic [N-1:0] t;
        int j;
        s = frame;
        for (int i = 1; i < s.size(); i++) begin
            j = i;
            while (j > 0 && greaterRef(s[j-1], s[j])) begin
                t = s[j-1]; s[j-1] = s[j]; s[j] = t;
                j--;
            end
        end
        for (int i = 0; i < s.size(); i++)
            expQ.push_back({(i == s.size() - 1), s[i]});
        for (int k = 0; k < frame.size(); k++) begin
            @(negedge clk);
            inValid = 1'b1;
            inData  = frame[k];
            inLast  = useLast && (k == frame.size() - 1);
            checkOutput("in_ready_load", obsInReady, 1);
            @(posedge clk);
        end
        @(negedge clk);
        inValid = 1'b0;
        inLast  = 1'b0;
    endtask

    task automatic measureSort(input int expLat);
        int lat = 0;
        checkOutput("busy_sort", obsBusy, 1);
        checkOutput("in_ready_sort", obsInReady, 0);
        checkOutput("out_valid_sort", obsOutValid, 0);
        while (obsBusy && !obsOutValid && lat < 300) begin
            lat++;
            @(negedge clk);
        end
        checkOutput("sort_done", obsOutValid, 1);
        if (expLat >= 0)
            checkOutput("sort_latency", lat, expLat);
    endtask

    task automatic drainFrame(input int stallAt);
        int guard = 0;
        int k = 0;
        int stalls = 0;
        logic [N-1:0] heldData = '0;
        logic         heldLast = 1'b0;
        logic [N:0]   expv;
        while (expQ.size() > 0 && guard < 400) begin
            guard++;
            outReady = !(k == stallAt && stalls < 3);
            if (obsOutValid) begin
                if (!outReady) begin
                    if (stalls == 0) begin
                        heldData = obsOutData;
                        heldLast = obsOutLast;
                    end else begin
                        checkOutput("stall_data", obsOutData, heldData);
                        checkOutput("stall_last", obsOutLast, heldLast);
                    end
                    stalls++;
                end else begin
                    expv = expQ.pop_front();
                    checkOutput("out_data", obsOutData, expv[N-1:0]);
                    checkOutput("out_last", obsOutLast, expv[N]);
                    k++;
                end
            end
            @(negedge clk);
        end
        checkOutput("drain_done", expQ.size(), 0);
        checkOutput("in_ready_after", obsInReady, 1);
        checkOutput("busy_after", obsBusy, 0);
        checkOutput("out_valid_after", obsOutValid, 0);
        checkOutput("out_data_after", obsOutData, 0);
    endtask

    initial begin
        rst = 1'b1; sel = 1'b0; inValid = 1'b0; inData = '0; inLast = 1'b0; outReady = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_in_ready", obsInReady, 1);
        checkOutput("rst_out_valid", obsOutValid, 0);
        checkOutput("rst_out_data", obsOutData, 0);
        checkOutput("rst_out_last", obsOutLast, 0);
        checkOutput("rst_busy", obsBusy, 0);

        $display("[TB] unsigned frame 3,1,2");
        frame = '{4'd3, 4'd1, 4'd2};
        applyStimulus(1'b1);
        measureSort(4);
        drainFrame(-1);

        $display("[TB] signed frame 7,8,0");
        sel = 1'b1;
        frame = '{4'h7, 4'h8, 4'h0};
        applyStimulus(1'b1);
        measureSort(4);
        drainFrame(-1);
        sel = 1'b0;

        $display("[TB] full reversed frame");
        frame = '{4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
        applyStimulus(1'b0);
        measureSort(56);
        drainFrame(-1);

        $display("[TB] single word");
        frame = '{4'd5};
        applyStimulus(1'b1);
        measureSort(1);
        drainFrame(-1);

        $display("[TB] backpressure mid-drain");
        frame = '{4'd9, 4'd3, 4'd12, 4'd0, 4'd6};
        applyStimulus(1'b1);
        measureSort(-1);
        drainFrame(2);

        $display("[TB] signed extremes with duplicates");
        sel = 1'b1;
        frame = '{4'hF, 4'h8, 4'h7, 4'h0, 4'h8, 4'h1};
        applyStimulus(1'b1);
        measureSort(-1);
        drainFrame(4);
        sel = 1'b0;

        $display("[TB] reset mid-sort");
        frame = '{4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
        applyStimulus(1'b0);
        expQ.delete();
        repeat (10) @(negedge clk);
        checkOutput("busy_pre_rst", obsBusy, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_in_ready", obsInReady, 1);
        checkOutput("abort_busy", obsBusy, 0);
        checkOutput("abort_out_valid", obsOutValid, 0);
        checkOutput("abort_out_data", obsOutData, 0);
        frame = '{4'd2, 4'd1};
        applyStimulus(1'b1);
        measureSort(2);
        drainFrame(-1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/sort_sequencer.md
SORT_SEQUENCER -- requirements
Module: sort_sequencer

Interface
REQ-001 SHALL have parameter N, default 4, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, maximum words per sort frame (DEPTH >= 2).
REQ-003 SHALL have parameter SIGNED, default 0; 1 = two's-complement ordering, 0 = unsigned ordering.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 in_valid  input  1  in_data/in_last are valid this cycle.
REQ-007 in_ready  output  1  block can accept an input word this cycle.
REQ-008 in_data  input  N  word to load.
REQ-009 in_last  input  1  final word of the frame.
REQ-010 out_valid  output  1  out_data/out_last are valid this cycle.
REQ-011 out_ready  input  1  downstream accepts the output word.
REQ-012 out_data  output  N  sorted word.
REQ-013 out_last  output  1  final sorted word of the frame.
REQ-014 busy  output  1  high while in SORT or DRAIN.

Function
REQ-015 SHALL implement states IDLE (no words held), LOAD (1..DEPTH-1 words held), SORT and DRAIN.
REQ-016 A transfer SHALL occur on an edge where valid and ready are both high, on either port.
REQ-017 in_ready SHALL be 1 in IDLE and LOAD, and 0 in SORT and DRAIN.
REQ-018 Each accepted word SHALL be written to mem[cnt], and cnt SHALL increment by 1.
REQ-019 IDLE SHALL go to LOAD on an accepted word with in_last=0.
REQ-020 IDLE or LOAD SHALL go to SORT on an accepted word with in_last=1, or when the accepted word makes cnt==DEPTH.
REQ-021 SORT SHALL perform one comparison per cycle between mem[i] and mem[i+1], for i = 0..cnt-2 within a pass.
REQ-022 Comparison SHALL be unsigned when SIGNED=0.
REQ-023 When SIGNED=1, comparison SHALL be two's-complement: if the MSBs differ, the word with MSB=1 is smaller; otherwise compare unsigned.
REQ-024 If mem[i] > mem[i+1], the two words SHALL be swapped in the same edge, giving ascending order.
REQ-025 Equal words SHALL NOT be swapped, so the sort is stable.
REQ-026 At the end of a pass (i==cnt-2): if any swap occurred in the pass, i SHALL reset to 0 and a new pass SHALL start; otherwise the state SHALL go to DRAIN.
REQ-027 With cnt==1, SORT SHALL last exactly one cycle and then go to DRAIN.
REQ-028 SORT latency SHALL be P*(cnt-1) cycles, where P is the number of passes, with 1 <= P <= cnt; already-sorted input gives P=1.
REQ-029 DRAIN SHALL drive out_valid=1 and out_data=mem[rd], with rd starting at 0.
REQ-030 rd SHALL advance by 1 on each output transfer.
REQ-031 out_last SHALL be 1 iff rd==cnt-1.
REQ-032 While out_valid=1 and out_ready=0, out_data and out_last SHALL hold stable.
REQ-033 The transfer with out_last=1 SHALL clear cnt, rd and i, and return the state to IDLE, so in_ready=1 on the next cycle.
REQ-034 in_valid SHALL be ignored in SORT and DRAIN; no words are lost because in_ready=0 there.
REQ-035 out_valid SHALL be 0 in IDLE, LOAD and SORT.
REQ-036 out_data SHALL be 0 whenever out_valid=0.
REQ-037 busy SHALL equal (state==SORT or state==DRAIN).

Reset
REQ-038 rst=1 at a clock edge SHALL force state=IDLE and cnt=rd=i=0, and clear the swap flag.
REQ-039 After reset: in_ready=1, out_valid=0, out_data=0, out_last=0, busy=0.
REQ-040 Reset SHALL take priority over all transfers in the same cycle.
REQ-041 Reset in any state, including mid-SORT or mid-DRAIN, SHALL abort the frame and discard held words.
REQ-042 Memory contents need not be cleared by reset.

Verification (N=4, DEPTH=8)
REQ-043 Unsigned frame: load 3,1,2 with in_last on 2 -> busy=1; outputs 1,2,3 in order; out_last=1 only on 3; then in_ready=1.
REQ-044 SIGNED=1 frame: load 4'h7,4'h8,4'h0 (last) -> outputs 4'h8, 4'h0, 4'h7.
REQ-045 Full frame: load 7,6,5,4,3,2,1,0 with in_last=0 throughout -> in_ready=0 after the 8th word; SORT lasts 8*7=56 cycles; outputs 0..7.
REQ-046 Single word: load 5 with in_last=1 -> SORT lasts 1 cycle; out_data=5 with out_last=1.
REQ-047 Backpressure: hold out_ready=0 for 3 cycles mid-DRAIN -> out_data and out_last unchanged; no word skipped or duplicated.
REQ-048 Reset mid-SORT: assert rst for 1 cycle -> next cycle in_ready=1, busy=0, out_valid=0; the next frame of 2,1 (last) outputs 1,2.
